write_scheduler: RTL and testbench

WRITE_SCHEDULER -- requirements
Module: write_scheduler

---
 rtl/tone_pkg.sv | 36 +++
 rtl/sched_fifo.sv | 70 +++++++
 rtl/write_scheduler.sv | 158 +++++++++++++++
 tb/tb_write_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the write scheduler: special addresses, queue entry
// layout and FSM encoding.
package tone_pkg;

  localparam logic [5:0] SCHED_WAIT_ADDR  = 6'h3F;
  localparam logic [5:0] SCHED_FLUSH_ADDR = 6'h3E;

  localparam int ENTRY_W = 1 + 6 + 16;

  typedef enum logic {
    ENT_WRITE = 1'b0,
    ENT_WAIT  = 1'b1
  } entry_type_t;

  typedef struct packed {
    entry_type_t etype;
    logic [5:0]  addr;
    logic [15:0] data;
  } entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } sched_state_t;

  function automatic entry_t make_entry(input logic       is_wait,
                                        input logic [5:0]  addr,
                                        input logic [15:0] data);
    entry_t e;
    e.etype = is_wait ? ENT_WAIT : ENT_WRITE;
    e.addr  = addr;
    e.data  = data;
    return e;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO holding pending scheduler entries; flush empties it and
// takes priority over push and pop in the same cycle.
module sched_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full     = (count_r == FULL_CNT);
  assign empty    = (count_r == {(PTR_W + 1){1'b0}});
  assign pop_data = mem_r[rd_ptr_r];

  // Accept only operations the current occupancy allows.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are meaningless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/write_scheduler.sv
// Host register-write scheduler: forwards writes immediately when idle, otherwise
// queues them, honouring WAIT entries that stall for a number of sample ticks.
// Optional sticky drop flag enabled by defining WRITE_SCHED_OVERFLOW_EN.
module write_scheduler
  import tone_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [9:0]  master_count_in,
  input  logic [15:0] data_in,
  input  logic [5:0]  addr_in,
  input  logic        data_valid_in,
  output logic [15:0] data_out,
  output logic [5:0]  addr_out,
  output logic        data_valid_out,
  output logic        busy_out,
  output logic        overflow_out
);

  sched_state_t state_r;
  logic [15:0]  wait_cnt_r;
  logic [15:0]  data_r;
  logic [5:0]   addr_r;
  logic         valid_r;

  entry_t       head_s;
  entry_t       push_entry_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  logic         tick_s;
  logic         is_flush_s;
  logic         is_wait_s;
  logic         is_write_s;
  logic         forward_s;
  logic         push_req_s;
  logic         push_s;
  logic         pop_s;

  // Classify the incoming write and decide forward / enqueue / pop for this cycle.
  always_comb begin
    tick_s       = (master_count_in == 10'd0);
    is_flush_s   = 1'b0;
    is_wait_s    = 1'b0;
    is_write_s   = 1'b0;
    if (data_valid_in) begin
      is_flush_s = (addr_in == SCHED_FLUSH_ADDR);
      is_wait_s  = (addr_in == SCHED_WAIT_ADDR);
      is_write_s = (addr_in != SCHED_FLUSH_ADDR) && (addr_in != SCHED_WAIT_ADDR);
    end else begin
      is_flush_s = 1'b0;
    end
    forward_s    = is_write_s && fifo_empty_s && (state_r == ST_IDLE);
    pop_s        = (state_r == ST_IDLE) && !fifo_empty_s && !is_flush_s;
    push_req_s   = is_wait_s || (is_write_s && !forward_s);
    if (push_req_s) begin
      push_s = !fifo_full_s;
    end else begin
      push_s = 1'b0;
    end
    push_entry_s = make_entry(is_wait_s, addr_in, data_in);
  end

  sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (reset_in),
    .flush     (is_flush_s),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Scheduler FSM with registered write outputs.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 16'd0;
      data_r     <= 16'd0;
      addr_r     <= 6'd0;
      valid_r    <= 1'b0;
    end else if (is_flush_s) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 16'd0;
      valid_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (forward_s) begin
            valid_r <= 1'b1;
            data_r  <= data_in;
            addr_r  <= addr_in;
          end else if (pop_s) begin
            if (head_s.etype == ENT_WRITE) begin
              valid_r <= 1'b1;
              data_r  <= head_s.data;
              addr_r  <= head_s.addr;
            end else if (head_s.data != 16'd0) begin
              wait_cnt_r <= head_s.data;
              state_r    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Leaving on the tick that exhausts the count lets the next pop
          // happen in the very next cycle.
          if (wait_cnt_r == 16'd0) begin
            state_r <= ST_IDLE;
          end else if (tick_s) begin
            wait_cnt_r <= wait_cnt_r - 16'd1;
            if (wait_cnt_r == 16'd1) begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          wait_cnt_r <= 16'd0;
        end
      endcase
    end
  end

  assign data_out       = data_r;
  assign addr_out       = addr_r;
  assign data_valid_out = valid_r;
  assign busy_out       = !fifo_empty_s || (state_r != ST_IDLE);

`ifdef WRITE_SCHED_OVERFLOW_EN
  logic overflow_r;
  logic drop_s;

  assign drop_s = push_req_s && fifo_full_s;

  // Sticky drop indicator, cleared only by flush or reset.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      overflow_r <= 1'b0;
    end else if (is_flush_s) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign overflow_out = overflow_r;
`else
  assign overflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_write_scheduler.sv
// Directed self-checking bench for write_scheduler (inputs change and outputs
// are sampled on the falling clock edge).
module tb_write_scheduler;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic [9:0]  master_count_in = 10'd1;
  logic [15:0] data_in = 16'd0;
  logic [5:0]  addr_in = 6'd0;
  logic        data_valid_in = 1'b0;
  logic [15:0] data_out;
  logic [5:0]  addr_out;
  logic        data_valid_out;
  logic        busy_out;
  logic        overflow_out;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef WRITE_SCHED_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  write_scheduler #(.FIFO_DEPTH(8)) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .master_count_in (master_count_in),
    .data_in         (data_in),
    .addr_in         (addr_in),
    .data_valid_in   (data_valid_in),
    .data_out        (data_out),
    .addr_out        (addr_out),
    .data_valid_out  (data_valid_out),
    .busy_out        (busy_out),
    .overflow_out    (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  // Apply inputs for one full cycle, then return the inputs to idle (no tick).
  task automatic drive(input logic [5:0] a, input logic [15:0] d, input logic v, input logic [9:0] mc);
    addr_in = a; data_in = d; data_valid_in = v; master_count_in = mc;
    @(negedge clk_in);
    addr_in = 6'd0; data_in = 16'd0; data_valid_in = 1'b0; master_count_in = 10'd1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    drive(a, d, 1'b1, 10'd1);
  endtask

  task automatic idle();
    drive(6'd0, 16'd0, 1'b0, 10'd1);
  endtask

  task automatic tick();
    drive(6'd0, 16'd0, 1'b0, 10'd0);
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    repeat (3) @(negedge clk_in);
    tests_run++; if (data_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_data: got %h expected 0000", data_out); end
    tests_run++; if (addr_out !== 6'h00) begin tests_failed++; $display("FAIL reset_addr: got %h expected 00", addr_out); end
    tests_run++; if (data_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", data_valid_out); end
    tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    tests_run++; if (overflow_out !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow_out); end
    reset_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_idle_write();
    wr(6'h05, 16'h1234);
    tests_run++; if (data_valid_out !== 1'b1) begin tests_failed++; $display("FAIL idle_valid: got %b expected 1", data_valid_out); end
    tests_run++; if (addr_out !== 6'h05) begin tests_failed++; $display("FAIL idle_addr: got %h expected 05", addr_out); end
    tests_run++; if (data_out !== 16'h1234) begin tests_failed++; $display("FAIL idle_data: got %h expected 1234", data_out); end
    idle();
    tests_run++; if (data_valid_out !== 1'b0) begin tests_failed++; $display("FAIL idle_pulse_width: got %b expected 0", data_valid_out); end
    tests_run++; if (data_out !== 16'h1234) begin tests_failed++; $display("FAIL idle_hold: got %h expected 1234", data_out); end
    tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b expected 0", busy_out); end
  endtask

  task automatic test_wait_then_write();
    int early = 0;
    wr(6'h3F, 16'h0002);
    tests_run++; if (busy_out !== 1'b1) begin tests_failed++; $display("FAIL wait_busy: got %b expected 1", busy_out); end
    wr(6'h05, 16'hAAAA);
    if (data_valid_out) early++;
    repeat (3) begin idle(); if (data_valid_out) early++; end
    tick();
    if (data_valid_out) early++;
    repeat (2) begin idle(); if (data_valid_out) early++; end
    tick();
    // Second tick releases WAIT; the queued write pops next cycle and shows one cycle later.
    tests_run++; if (data_valid_out !== 1'b0) begin tests_failed++; $display("FAIL wait_tick2_valid: got %b expected 0", data_valid_out); end
    tests_run++; if (early !== 0) begin tests_failed++; $display("FAIL wait_early_pulses: got %0d expected 0", early); end
    idle();
    tests_run++; if (data_valid_out !== 1'b1) begin tests_failed++; $display("FAIL wait_emit_valid: got %b expected 1", data_valid_out); end
    tests_run++; if (data_out !== 16'hAAAA) begin tests_failed++; $display("FAIL wait_emit_data: got %h expected aaaa", data_out); end
    tests_run++; if (addr_out !== 6'h05) begin tests_failed++; $display("FAIL wait_emit_addr: got %h expected 05", addr_out); end
    idle();
    tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL wait_done_busy: got %b expected 0", busy_out); end
  endtask

  task automatic test_wait_zero();
    wr(6'h3F, 16'h0000);
    wr(6'h07, 16'h0001);
    tests_run++; if (data_valid_out !== 1'b0) begin tests_failed++; $display("FAIL w0_queued_valid: got %b expected 0", data_valid_out); end
    idle();
    tests_run++; if (data_valid_out !== 1'b1) begin tests_failed++; $display("FAIL w0_valid: got %b expected 1", data_valid_out); end
    tests_run++; if (addr_out !== 6'h07) begin tests_failed++; $display("FAIL w0_addr: got %h expected 07", addr_out); end
    tests_run++; if (data_out !== 16'h0001) begin tests_failed++; $display("FAIL w0_data: got %h expected 0001", data_out); end
    idle();
  endtask

  task automatic test_back_to_back();
    wr(6'h3F, 16'h0001);
    wr(6'h10, 16'h1111);
    wr(6'h11, 16'h2222);
    wr(6'h12, 16'h3333);
    tick();
    tests_run++; if (data_valid_out !== 1'b0) begin tests_failed++; $display("FAIL b2b_pre_valid: got %b expected 0", data_valid_out); end
    idle();
    tests_run++; if (data_valid_out !== 1'b1 || addr_out !== 6'h10 || data_out !== 16'h1111) begin tests_failed++; $display("FAIL b2b_first: got v=%b a=%h d=%h expected v=1 a=10 d=1111", data_valid_out, addr_out, data_out); end
    idle();
    tests_run++; if (data_valid_out !== 1'b1 || addr_out !== 6'h11 || data_out !== 16'h2222) begin tests_failed++; $display("FAIL b2b_second: got v=%b a=%h d=%h expected v=1 a=11 d=2222", data_valid_out, addr_out, data_out); end
    idle();
    tests_run++; if (data_valid_out !== 1'b1 || addr_out !== 6'h12 || data_out !== 16'h3333) begin tests_failed++; $display("FAIL b2b_third: got v=%b a=%h d=%h expected v=1 a=12 d=3333", data_valid_out, addr_out, data_out); end
    idle();
    tests_run++; if (data_valid_out !== 1'b0 || busy_out !== 1'b0) begin tests_failed++; $display("FAIL b2b_end: got v=%b busy=%b expected v=0 busy=0", data_valid_out, busy_out); end
  endtask

  task automatic test_flush_vs_pop();
    wr(6'h3F, 16'h0004);
    wr(6'h3E, 16'h0000);
    tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL flushpop_busy: got %b expected 0", busy_out); end
    tests_run++; if (data_valid_out !== 1'b0) begin tests_failed++; $display("FAIL flushpop_valid: got %b expected 0", data_valid_out); end
    wr(6'h05, 16'hBEEF);
    tests_run++; if (data_valid_out !== 1'b1 || data_out !== 16'hBEEF) begin tests_failed++; $display("FAIL flushpop_forward: got v=%b d=%h expected v=1 d=beef", data_valid_out, data_out); end
    idle();
  endtask

  task automatic test_overflow();
    // Park the scheduler in WAIT first so the queue is not drained while filling.
    wr(6'h3F, 16'h0005);
    idle();
    for (int i = 0; i < 8; i++) wr(6'h3F, 16'h0003);
    tests_run++; if (overflow_out !== 1'b0) begin tests_failed++; $display("FAIL ovf_at_full: got %b expected 0", overflow_out); end
    tests_run++; if (busy_out !== 1'b1) begin tests_failed++; $display("FAIL ovf_busy: got %b expected 1", busy_out); end
    wr(6'h3F, 16'h0003);
    tests_run++; if (overflow_out !== OVF_EXP) begin tests_failed++; $display("FAIL ovf_drop: got %b expected %b", overflow_out, OVF_EXP); end
    idle();
    tests_run++; if (overflow_out !== OVF_EXP) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected %b", overflow_out, OVF_EXP); end
    wr(6'h3E, 16'h0000);
    tests_run++; if (overflow_out !== 1'b0) begin tests_failed++; $display("FAIL ovf_flush_clear: got %b expected 0", overflow_out); end
    tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL ovf_flush_busy: got %b expected 0", busy_out); end
    wr(6'h06, 16'h5A5A);
    tests_run++; if (data_valid_out !== 1'b1 || addr_out !== 6'h06 || data_out !== 16'h5A5A) begin tests_failed++; $display("FAIL ovf_after_flush: got v=%b a=%h d=%h expected v=1 a=06 d=5a5a", data_valid_out, addr_out, data_out); end
    idle();
  endtask

  task automatic test_reset_mid_wait();
    int pulses = 0;
    wr(6'h3F, 16'h0005);
    wr(6'h20, 16'h00C1);
    wr(6'h21, 16'h00C2);
    wr(6'h22, 16'h00C3);
    wr(6'h23, 16'h00C4);
    tests_run++; if (busy_out !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_busy: got %b expected 1", busy_out); end
    #2 reset_in = 1'b0;
    #1;
    tests_run++; if (data_out !== 16'h0000 || addr_out !== 6'h00) begin tests_failed++; $display("FAIL rst_async_data: got a=%h d=%h expected a=00 d=0000", addr_out, data_out); end
    tests_run++; if (data_valid_out !== 1'b0 || busy_out !== 1'b0 || overflow_out !== 1'b0) begin tests_failed++; $display("FAIL rst_async_flags: got v=%b busy=%b ovf=%b expected 0 0 0", data_valid_out, busy_out, overflow_out); end
    @(negedge clk_in);
    reset_in = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(); if (data_valid_out) pulses++; end
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL rst_no_emit: got %0d pulses expected 0", pulses); end
    tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL rst_post_busy: got %b expected 0", busy_out); end
  endtask

  initial begin
    test_reset();
    test_idle_write();
    test_wait_then_write();
    test_wait_zero();
    test_back_to_back();
    test_flush_vs_pop();
    test_overflow();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
